// File: rtl/led_flow_sched.sv
// led_flow_sched: scheduler and sequencer for the 4-LED flow-pattern engine.
// It generates the alternating short/long step tick. It chooses the active
// pattern (out of 8) and the step within that pattern. After a per-pattern
// dwell it moves on to the next pattern. It also accepts pre-debounced key
// pulses for next, pause and speed.
//
// Optional feature macro: LED_SCHED_DIR_EN adds key_dir/dir. The direction
// bit reverses the order in which patterns are stepped through.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   key_next            pulse: switch to the next pattern now
//   key_pause           pulse: toggle between RUN and PAUSE
//   key_speed           pulse: cycle speed 0->1->2->0 (period >> speed)
//   key_dir / dir       (LED_SCHED_DIR_EN only) toggle / current direction
//   pat_sel, step       active pattern index and step within it
//   step_stb            one-cycle pulse when step advances
//   pat_start           one-cycle pulse when a pattern (re)starts
//   paused, speed       status
module led_flow_sched #(
  parameter int TICK_SHORT = 12500000,
  parameter int TICK_LONG  = 25000000,
  parameter int CNT_W      = 26
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_next,
  input  logic       key_pause,
  input  logic       key_speed,
`ifdef LED_SCHED_DIR_EN
  input  logic       key_dir,
  output logic       dir,
`endif
  output logic [2:0] pat_sel,
  output logic [1:0] step,
  output logic       step_stb,
  output logic       pat_start,
  output logic       paused,
  output logic [1:0] speed
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [CNT_W-1:0] PER_SHORT = CNT_W'(TICK_SHORT);
  localparam logic [CNT_W-1:0] PER_LONG  = CNT_W'(TICK_LONG);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;     // 0 = short period, 1 = long
  logic [2:0]       dwell_q, dwell_d;
  logic [2:0]       pat_q, pat_d;
  logic [1:0]       step_q, step_d;
  logic [1:0]       speed_q, speed_d;
  logic             stb_q, stb_d;
  logic             start_q, start_d;
`ifdef LED_SCHED_DIR_EN
  logic             dir_q, dir_d;
`endif

  logic [CNT_W-1:0] period;
  logic             tick, tick_eff, down, two_step;
  logic [1:0]       step_last;
  logic [2:0]       dwell_last, nxt_pat;

  // Patterns 0, 3 and 6 have 2 steps and a dwell of 6 ticks. All other
  // patterns have 4 steps and a dwell of 5 ticks.
  assign two_step   = (pat_q == 3'd0) || (pat_q == 3'd3) || (pat_q == 3'd6);
  assign step_last  = two_step ? 2'd1 : 2'd3;
  assign dwell_last = two_step ? 3'd5 : 3'd4;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    pat_d   = pat_q;
    step_d  = step_q;
    speed_d = speed_q;
    stb_d   = 1'b0;
    start_d = 1'b0;
    down    = 1'b0;
`ifdef LED_SCHED_DIR_EN
    // A direction toggle in the same cycle as a switch already steers that switch.
    dir_d = dir_q ^ key_dir;
    down  = dir_d;
`endif
    period   = (phase_q ? PER_LONG : PER_SHORT) >> speed_q;
    tick     = (state_q == S_RUN) && (cnt_q == period - CNT_ONE);
    // Both key_next and key_speed swallow a coincident tick.
    tick_eff = tick && !key_next && !key_speed;
    nxt_pat  = down ? pat_q - 3'd1 : pat_q + 3'd1;

    if (state_q == S_START) begin
      state_d = S_RUN;
      start_d = 1'b1;
    end else begin
      if (key_pause) state_d = (state_q == S_PAUSE) ? S_RUN : S_PAUSE;

      if (key_next || (tick_eff && (dwell_q == dwell_last))) begin
        pat_d   = nxt_pat;
        step_d  = '0;
        dwell_d = '0;
        phase_d = 1'b0;
        cnt_d   = '0;
        start_d = 1'b1;
      end else if (tick_eff) begin
        step_d  = (step_q == step_last) ? 2'd0 : step_q + 2'd1;
        dwell_d = dwell_q + 3'd1;
        stb_d   = 1'b1;
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else if (state_q == S_RUN) begin
        cnt_d = cnt_q + CNT_ONE;
      end

      if (key_speed) begin
        speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_START;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      dwell_q <= '0;
      pat_q   <= '0;
      step_q  <= '0;
      speed_q <= '0;
      stb_q   <= 1'b0;
      start_q <= 1'b0;
`ifdef LED_SCHED_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
      speed_q <= speed_d;
      stb_q   <= stb_d;
      start_q <= start_d;
`ifdef LED_SCHED_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign pat_sel   = pat_q;
  assign step      = step_q;
  assign step_stb  = stb_q;
  assign pat_start = start_q;
  assign paused    = (state_q == S_PAUSE);
  assign speed     = speed_q;
`ifdef LED_SCHED_DIR_EN
  assign dir       = dir_q;
`endif

endmodule

// File: tb/tb_led_flow_sched.sv
module tb_led_flow_sched;

  localparam int TS = 4;
  localparam int TL = 8;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_next, key_pause, key_speed;
  logic [2:0] pat_sel;
  logic [1:0] step;
  logic       step_stb, pat_start, paused;
  logic [1:0] speed;
  logic       dir_w;
`ifdef LED_SCHED_DIR_EN
  logic       key_dir, dir;
  assign dir_w = dir;
`else
  assign dir_w = 1'b0;
`endif

  led_flow_sched #(.TICK_SHORT(TS), .TICK_LONG(TL), .CNT_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_next  (key_next),
    .key_pause (key_pause),
    .key_speed (key_speed),
`ifdef LED_SCHED_DIR_EN
    .key_dir   (key_dir),
    .dir       (dir),
`endif
    .pat_sel   (pat_sel),
    .step      (step),
    .step_stb  (step_stb),
    .pat_start (pat_start),
    .paused    (paused),
    .speed     (speed)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, stepped once per rising edge
  int ST_N[8] = '{2, 4, 4, 2, 4, 4, 2, 4};
  int DW_N[8] = '{6, 5, 5, 6, 5, 5, 6, 5};
  int m_state, m_cnt, m_phase, m_dwell, m_pat, m_step, m_speed, m_dir;
  bit m_stb, m_start;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_phase = 0; m_dwell = 0; m_pat = 0;
    m_step = 0; m_speed = 0; m_dir = 0; m_stb = 0; m_start = 0;
  endtask

  function automatic int m_period();
    return (m_phase != 0 ? TL : TS) >> m_speed;
  endfunction

  function automatic bit m_tick_pending();
    return (m_state == 1) && (m_cnt == m_period() - 1);
  endfunction

  task automatic model_step(input bit kn, input bit kp, input bit ks, input bit kd);
    bit tk, run;
    m_stb = 0;
    m_start = 0;
    m_dir = m_dir ^ int'(kd);
    if (m_state == 0) begin
      m_state = 1;
      m_start = 1;
      return;
    end
    tk  = m_tick_pending();
    run = (m_state == 1);
    if (kp) m_state = (m_state == 2) ? 1 : 2;
    if (kn || (tk && !ks && m_dwell == DW_N[m_pat] - 1)) begin
      m_pat = (m_dir != 0) ? (m_pat + 7) % 8 : (m_pat + 1) % 8;
      m_step = 0; m_dwell = 0; m_phase = 0; m_cnt = 0; m_start = 1;
    end else if (tk && !ks) begin
      m_step = (m_step + 1) % ST_N[m_pat];
      m_dwell++;
      m_stb = 1;
      m_cnt = 0;
      m_phase = 1 - m_phase;
    end else if (run && !ks) begin
      m_cnt++;
    end
    if (ks) begin
      m_speed = (m_speed + 1) % 3;
      m_cnt = 0;
    end
  endtask

  function automatic logic [10:0] model_vec();
    return {3'(m_pat), 2'(m_step), m_stb, m_start, (m_state == 2), 2'(m_speed), 1'(m_dir)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {pat_sel, step, step_stb, pat_start, paused, speed, dir_w};
  endfunction

  logic [10:0] exp_q[$];
  int cyc;
  int stb_t[$], evt_t[$], start_t[$], pat_hist[$], step_hist[$];

  task automatic cycle(input bit kn, input bit kp, input bit ks, input bit kd);
    logic [10:0] e;
    key_next = kn; key_pause = kp; key_speed = ks;
`ifdef LED_SCHED_DIR_EN
    key_dir = kd;
`endif
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step(kn, kp, ks, kd);
    exp_q.push_back(model_vec());
    @(negedge sys_clk);
    cyc++;
    e = exp_q.pop_front();
    check_eq("outs", 32'(dut_vec()), 32'(e));
    if (step_stb) begin
      stb_t.push_back(cyc);
      step_hist.push_back(int'(step));
    end
    if (step_stb || pat_start) evt_t.push_back(cyc);
    if (pat_start) begin
      start_t.push_back(cyc);
      pat_hist.push_back(int'(pat_sel));
    end
    key_next = 0; key_pause = 0; key_speed = 0;
`ifdef LED_SCHED_DIR_EN
    key_dir = 0;
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n, rc, rem, d, ones, twos, old;
    bit found;
    sys_rst_n = 1'b0;
    key_next = 0; key_pause = 0; key_speed = 0;
`ifdef LED_SCHED_DIR_EN
    key_dir = 0;
`endif
    model_reset();
    cyc = 0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_outs", 32'(dut_vec()), 32'd0);
    sys_rst_n = 1'b1;

    // Free run: spacing of the first step strobes and one full pattern cycle
    repeat (400) cycle(0, 0, 0, 0);
    check_eq("start_lat", 32'(start_t.size() > 0 ? start_t[0] : -1), 32'd1);
    check_eq("stb_cnt_ok", 32'(stb_t.size() >= 5), 32'd1);
    if (stb_t.size() >= 5) begin
      check_eq("ivl0", 32'(stb_t[0] - start_t[0]), 32'd4);
      check_eq("ivl1", 32'(stb_t[1] - stb_t[0]), 32'd8);
      check_eq("ivl2", 32'(stb_t[2] - stb_t[1]), 32'd4);
      check_eq("ivl3", 32'(stb_t[3] - stb_t[2]), 32'd8);
      for (int i = 0; i < 5; i++) check_eq("p0_step", 32'(step_hist[i]), 32'(i % 2 == 0 ? 1 : 0));
    end
    check_eq("start_cnt_ok", 32'(start_t.size() >= 9), 32'd1);
    if (start_t.size() >= 9) begin
      check_eq("p0_dwell", 32'(start_t[1] - start_t[0]), 32'd36);
      for (int i = 1; i <= 8; i++) check_eq("pat_seq", 32'(pat_hist[i]), 32'(i % 8));
      check_eq("full_cycle", 32'(start_t[8] - start_t[0]), 32'd248);
    end

    // Pause mid-period, hold, resume from the frozen count
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_state == 1 && m_cnt == 1) found = 1;
      else cycle(0, 0, 0, 0);
    end
    check_eq("pause_align", 32'(found), 32'd1);
    cycle(0, 1, 0, 0);
    rem = m_period() - m_cnt;
    n = evt_t.size();
    repeat (20) cycle(0, 0, 0, 0);
    check_eq("paused_hi", 32'(paused), 32'd1);
    check_eq("pause_nostb", 32'(evt_t.size() - n), 32'd0);
    cycle(0, 1, 0, 0);
    rc = cyc;
    check_eq("paused_lo", 32'(paused), 32'd0);
    for (int i = 0; i < 20 && evt_t.size() == n; i++) cycle(0, 0, 0, 0);
    check_eq("resume_seen", 32'(evt_t.size() > n), 32'd1);
    if (evt_t.size() > n) check_eq("resume_delay", 32'(evt_t[n] - rc), 32'(rem));

    // Speed up twice: tick intervals must be 1 or 2 cycles
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check_eq("speed2", 32'(speed), 32'd2);
    n = evt_t.size();
    repeat (14) cycle(0, 0, 0, 0);
    ones = 0; twos = 0;
    check_eq("spd_evts", 32'(evt_t.size() - n >= 6), 32'd1);
    for (int i = n + 1; i < evt_t.size(); i++) begin
      d = evt_t[i] - evt_t[i-1];
      check_eq("spd_ivl", 32'(d >= 1 && d <= 2), 32'd1);
      if (d == 1) ones++;
      if (d == 2) twos++;
    end
    check_eq("spd_mix", 32'(ones > 0 && twos > 0), 32'd1);
    cycle(0, 0, 1, 0);
    check_eq("speed0", 32'(speed), 32'd0);

    // key_next on the very cycle of a tick
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_tick_pending()) found = 1;
      else cycle(0, 0, 0, 0);
    end
    check_eq("tick_found", 32'(found), 32'd1);
    old = m_pat;
    cycle(1, 0, 0, 0);
    check_eq("coll_start", 32'(pat_start), 32'd1);
    check_eq("coll_nostb", 32'(step_stb), 32'd0);
    check_eq("coll_step", 32'(step), 32'd0);
    check_eq("coll_pat", 32'(pat_sel), 32'((old + 1) % 8));
    cycle(0, 0, 0, 0);
    check_eq("coll_once", 32'(pat_sel), 32'((old + 1) % 8));
    check_eq("coll_pulse", 32'(pat_start), 32'd0);

    // Combined keys: pause+next, then pause+speed
    cycle(1, 1, 0, 0);
    check_eq("pn_paused", 32'(paused), 32'd1);
    check_eq("pn_start", 32'(pat_start), 32'd1);
    cycle(0, 1, 1, 0);
    check_eq("ps_speed", 32'(speed), 32'd1);
    check_eq("ps_run", 32'(paused), 32'd0);
    repeat (30) cycle(0, 0, 0, 0);

`ifdef LED_SCHED_DIR_EN
    for (int i = 0; i < 8 && m_pat != 0; i++) cycle(1, 0, 0, 0);
    check_eq("dir_at0", 32'(pat_sel), 32'd0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    check_eq("dir_pat7", 32'(pat_sel), 32'd7);
    check_eq("dir_hi", 32'(dir), 32'd1);
    cycle(1, 0, 0, 1);
    check_eq("dir_coinc", 32'(pat_sel), 32'd0);
    check_eq("dir_lo", 32'(dir), 32'd0);
`endif

    // Asynchronous reset mid-operation
    repeat (3) cycle(0, 0, 0, 0);
    sys_rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(dut_vec()), 32'd0);
    model_reset();
    repeat (2) cycle(0, 0, 0, 0);
    sys_rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    check_eq("rerst_start", 32'(pat_start), 32'd1);
    cycle(0, 0, 0, 0);
    check_eq("rerst_pulse", 32'(pat_start), 32'd0);
    repeat (20) cycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
